// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bus of the 2-bit branch predictor.
// The pipeline drives the master modport and the predictor sits on the slave modport.
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    // Valid-only protocol with no back-pressure: pred_valid and upd_valid each mark
    // a transfer in the cycle they are high. The predictor always accepts the
    // transfer, so there is no ready signal.
    logic            pred_valid;
    logic [XLEN-1:0] pred_pc;
    logic            pred_taken;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic [6:0]      upd_op;
    logic            upd_taken;
    logic            upd_pred;
    logic            mispredict;
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispred;

    modport master (
        output pred_valid, pred_pc, upd_valid, upd_pc, upd_op, upd_taken, upd_pred,
        input  pred_taken, mispredict, stat_branches, stat_mispred
    );

    modport slave (
        input  pred_valid, pred_pc, upd_valid, upd_pc, upd_op, upd_taken, upd_pred,
        output pred_taken, mispredict, stat_branches, stat_mispred
    );
endinterface

// File: rtl/branch_predictor.sv
// Per-PC 2-bit saturating-counter branch predictor, untagged, indexed by pc[IDX_BITS+1:2].
// Optional feature macro BP_STATS_EN builds the branch and mispredict statistics counters.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int XLEN     = 32
) (
    input logic               clk,
    input logic               reset_n,
    branch_predictor_if.slave bp
);
    localparam int         ENTRIES   = 1 << IDX_BITS;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;

    logic [1:0]          cnt_table [ENTRIES];
    logic [IDX_BITS-1:0] pred_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic                upd_qual;
    logic                upd_miss;
    logic [1:0]          upd_cur;
    logic [1:0]          upd_next;
    logic                mispredict_q;
    logic                unused_pc_bits;

    assign pred_idx = bp.pred_pc[IDX_BITS+1:2];
    assign upd_idx  = bp.upd_pc[IDX_BITS+1:2];
    assign upd_qual = bp.upd_valid && (bp.upd_op == OP_BRANCH);
    assign upd_miss = bp.upd_taken != bp.upd_pred;

    // The upper PC bits and the byte offset do not select an entry.
    assign unused_pc_bits = ^{bp.pred_pc[XLEN-1:IDX_BITS+2], bp.pred_pc[1:0],
                              bp.upd_pc[XLEN-1:IDX_BITS+2], bp.upd_pc[1:0]};

    // The lookup reads the registered table, so a same-cycle update is not forwarded.
    always_comb begin
        bp.pred_taken = 1'b0;
        if (bp.pred_valid) begin
            bp.pred_taken = cnt_table[pred_idx][1];
        end
    end

    always_comb begin
        upd_cur  = cnt_table[upd_idx];
        upd_next = upd_cur;
        if (bp.upd_taken) begin
            if (upd_cur != 2'b11) begin
                upd_next = upd_cur + 2'd1;
            end
        end else if (upd_cur != 2'b00) begin
            upd_next = upd_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_table[i] <= 2'b01;
            end
            mispredict_q <= 1'b0;
        end else begin
            if (upd_qual) begin
                cnt_table[upd_idx] <= upd_next;
            end
            mispredict_q <= upd_qual && upd_miss;
        end
    end

    assign bp.mispredict = mispredict_q;

`ifdef BP_STATS_EN
    logic [31:0] branches_q;
    logic [31:0] mispred_q;

    // Both counters wrap naturally at 32 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branches_q <= 32'd0;
            mispred_q  <= 32'd0;
        end else if (upd_qual) begin
            branches_q <= branches_q + 32'd1;
            if (upd_miss) begin
                mispred_q <= mispred_q + 32'd1;
            end
        end
    end

    assign bp.stat_branches = branches_q;
    assign bp.stat_mispred  = mispred_q;
`else
    assign bp.stat_branches = 32'd0;
    assign bp.stat_mispred  = 32'd0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with an expected-response queue and a negedge monitor.
// Statistic expectations follow whether BP_STATS_EN is defined.
module tb_branch_predictor;
    localparam logic [6:0] OP_BR  = 7'b110_0011;
    localparam logic [6:0] OP_JAL = 7'b110_1111;
    localparam logic [6:0] OP_NONE = 7'b000_0000;
`ifdef BP_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif
    // Expected record layout: {vector index[7:0], pred_taken, mispredict, stat_branches, stat_mispred}
    localparam int W = 74;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    branch_predictor_if #(.XLEN(32)) bus ();

    branch_predictor #(.IDX_BITS(6), .XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bp      (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int vec_idx = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // One cycle of stimulus: drive just after the rising edge, push what the
    // monitor should see at the following falling edge.
    task automatic step(input bit rst, input bit drop, input bit pv, input logic [31:0] ppc,
                        input bit uv, input logic [31:0] upc, input logic [6:0] op,
                        input bit ut, input bit up, input bit ept, input bit emp,
                        input int ebr, input int ems);
        logic [31:0] br;
        logic [31:0] ms;
        @(posedge clk);
        #1;
        reset_n        = rst;
        bus.pred_valid = pv;
        bus.pred_pc    = ppc;
        bus.upd_valid  = uv;
        bus.upd_pc     = upc;
        bus.upd_op     = op;
        bus.upd_taken  = ut;
        bus.upd_pred   = up;
        br = STATS_EN ? ebr : 0;
        ms = STATS_EN ? ems : 0;
        exp_q.push_back({vec_idx[7:0], ept, emp, br, ms});
        vec_idx++;
        if (drop) begin
            #2;
            reset_n = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        int idx;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            idx = int'(e[73:66]);
            check("pred_taken",    idx, {31'd0, bus.pred_taken}, {31'd0, e[65]});
            check("mispredict",    idx, {31'd0, bus.mispredict}, {31'd0, e[64]});
            check("stat_branches", idx, bus.stat_branches, e[63:32]);
            check("stat_mispred",  idx, bus.stat_mispred, e[31:0]);
        end
    end

    initial begin
        bus.pred_valid = 1'b0;
        bus.pred_pc    = 32'd0;
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = 32'd0;
        bus.upd_op     = OP_NONE;
        bus.upd_taken  = 1'b0;
        bus.upd_pred   = 1'b0;

        //   rst drop pv  pred_pc  uv  upd_pc  op     ut  up  pt  mp  br  ms
        // reset state
        step(0, 0, 1, 32'h000, 0, 32'h000, OP_NONE, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h0FC, 0, 32'h000, OP_NONE, 0, 0, 0, 0, 0, 0);
        // train 0x10 up to saturation: 01 -> 10 -> 11 -> 11
        step(1, 0, 1, 32'h010, 1, 32'h010, OP_BR,   1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h010, 1, 32'h010, OP_BR,   1, 0, 1, 1, 1, 1);
        step(1, 0, 1, 32'h010, 1, 32'h010, OP_BR,   1, 0, 1, 1, 2, 2);
        step(1, 0, 1, 32'h010, 0, 32'h000, OP_NONE, 0, 0, 1, 1, 3, 3);
        // JAL on untouched entry 0x30 must not train, pulse or count
        step(1, 0, 1, 32'h030, 1, 32'h030, OP_JAL,  1, 0, 0, 0, 3, 3);
        step(1, 0, 1, 32'h030, 0, 32'h000, OP_NONE, 0, 0, 0, 0, 3, 3);
        // train 0x10 down: 11 -> 10 -> 01 -> 00 -> 00 (saturate), then back to 01
        step(1, 0, 1, 32'h010, 1, 32'h010, OP_BR,   0, 0, 1, 0, 3, 3);
        step(1, 0, 1, 32'h010, 1, 32'h010, OP_BR,   0, 1, 1, 0, 4, 3);
        step(1, 0, 1, 32'h010, 1, 32'h010, OP_BR,   0, 0, 0, 1, 5, 4);
        step(1, 0, 1, 32'h010, 1, 32'h010, OP_BR,   0, 0, 0, 0, 6, 4);
        step(1, 0, 1, 32'h010, 0, 32'h000, OP_NONE, 0, 0, 0, 0, 7, 4);
        step(1, 0, 1, 32'h010, 1, 32'h010, OP_BR,   1, 0, 0, 0, 7, 4);
        step(1, 0, 1, 32'h010, 0, 32'h000, OP_NONE, 0, 0, 0, 1, 8, 5);
        // aliasing: 0x004 and 0x104 share index 1
        step(1, 0, 1, 32'h104, 1, 32'h004, OP_BR,   1, 1, 0, 0, 8, 5);
        step(1, 0, 1, 32'h104, 0, 32'h000, OP_NONE, 0, 0, 1, 0, 9, 5);
        // same-cycle lookup/update on 0x20 returns the old value
        step(1, 0, 1, 32'h020, 1, 32'h020, OP_BR,   1, 0, 0, 0, 9, 5);
        step(1, 0, 1, 32'h020, 0, 32'h000, OP_NONE, 0, 0, 1, 1, 10, 6);
        // no lookup request forces not-taken
        step(1, 0, 0, 32'h020, 0, 32'h000, OP_NONE, 0, 0, 0, 0, 10, 6);
        // reset dropped mid-cycle during a mispredicted update
        step(1, 1, 1, 32'h020, 1, 32'h020, OP_BR,   1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h020, 0, 32'h000, OP_NONE, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h104, 0, 32'h000, OP_NONE, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Per-PC 2-bit saturating-counter branch predictor for the RV32I core. Fetch looks up a taken/not-taken guess for the current PC. Execute returns the resolved outcome of each conditional branch, taken from the branch-condition decoder's PCSrc. The block trains the counter table and raises a registered mispredict pulse that the pipeline control uses to flush and redirect.

## Interface
Parameters:
- IDX_BITS, 6, log2 of the number of table entries (64 entries by default).
- XLEN, 32, PC width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pred_valid  in  1  fetch lookup request this cycle.
- pred_pc  in  XLEN  PC of the instruction being fetched.
- pred_taken  out  1  predicted direction for pred_pc; combinational from the table.
- upd_valid  in  1  resolved instruction present at execute.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_op  in  7  opcode of the resolved instruction.
- upd_taken  in  1  actual outcome (PCSrc).
- upd_pred  in  1  prediction that travelled with the instruction.
- mispredict  out  1  registered one-cycle flush pulse.
- stat_branches  out  32  count of conditional branches resolved.
- stat_mispred  out  32  count of mispredictions.

## Operation
- Table: 2^IDX_BITS entries, 2 bits each. Encoding: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
- Index: pc[IDX_BITS+1:2]. No tag; aliasing is allowed. pc[1:0] is ignored.
- Lookup: pred_taken = table[idx(pred_pc)][1] whenever pred_valid=1. pred_taken=0 when pred_valid=0.
- Update qualifier: upd_valid=1 and upd_op=7'b110_0011 (conditional branch).
  - JAL/JALR and all other opcodes never touch the table.
  - They never raise mispredict.
  - They never change the stat counters.
- Training on a qualified update:
  - If upd_taken=1, the entry increments, saturating at 11.
  - If upd_taken=0, the entry decrements, saturating at 00.
- Mispredict: on a qualified update with upd_taken != upd_pred, mispredict=1 in the following cycle only. Otherwise mispredict=0.
- Back-to-back qualified updates each produce an independent pulse. Consecutive mispredicts give mispredict high for consecutive cycles.

## Timing
- Reset (reset_n=0, asynchronous):
  - Every table entry becomes 01.
  - mispredict becomes 0.
  - stat_branches and stat_mispred become 0.
  - pred_taken reads 0 as a consequence of the table reset.
- Reset asserted mid-operation discards any pending mispredict pulse and any training write in flight.
- Lookup latency: 0 cycles (combinational).
- Training latency: the new value is visible to a lookup on the cycle after the update edge.
- Same-index lookup and update in one cycle: the lookup returns the pre-update value. There is no forwarding.
- mispredict latency: exactly 1 cycle after the upd_valid cycle. Pulse width: 1 cycle per mispredicted branch.

## Configuration
- BP_STATS_EN defined:
  - stat_branches increments by 1 on every qualified update.
  - stat_mispred increments by 1 on every qualified update with upd_taken != upd_pred.
  - Both are 32-bit registers that wrap from 0xFFFFFFFF to 0.
  - Counts are visible the cycle after the update.
- BP_STATS_EN undefined: no counter flops are built, and stat_branches and stat_mispred are tied to 0. The port list is unchanged.

## Test plan
- Reset state: deassert reset_n, look up pred_pc=0x00000000 and 0x000000FC -> pred_taken=0, mispredict=0, both stats 0.
- Training and saturation at pc=0x00000010, upd_op=1100011:
  - Three updates with upd_taken=1, upd_pred=0 -> entry goes 01→10→11→11; pred_taken=1 from the cycle after the first update.
  - mispredict pulses on 3 consecutive cycles.
  - With BP_STATS_EN: stat_branches=3, stat_mispred=3.
- Non-branch filter: upd_valid=1, upd_op=1101111 (JAL), upd_taken=1, upd_pred=0 -> no table change, mispredict stays 0, stats unchanged.
- Aliasing: train pc=0x00000004 to taken, then look up pc=0x00000104 with IDX_BITS=6 -> pred_taken=1 (same index 1).
- Same-cycle hazard: entry at 0x20 is 01; update taken and look up 0x20 in the same cycle -> pred_taken=0 that cycle, 1 the next.
- Reset mid-pulse: a mispredicted update, with reset_n dropped before the next edge -> mispredict stays 0, the table returns to 01, and the stats are 0.
